tdm_demux8: RTL and testbench

Receive end of an 8-channel time-division link. The transmit end scans an 8:1 mux with a 3-bit slot counter and marks slot 0 with a frame sync. This block recovers slot alignment from that sync and demultiplexes the serial stream back into 8 registered channel outputs. It publishes one complete frame per 8 accepted samples and tracks lock and sync errors.

---
 rtl/tdm_demux8.sv | 148 ++++++++++++++
 tb/tb_tdm_demux8.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/tdm_demux8.sv
// tdm_demux8: receive end of an 8-channel TDM link. Recovers slot alignment
// from fsync and demuxes the serial stream into a registered 8-channel frame.
// Ports: clk, rst_n (async, active low), en (sample strobe), din, fsync,
//   q (channel k at q[k*DATA_W +: DATA_W]), frame_valid, sel, locked, sync_err
//   and parity_err when TDM_DEMUX_PARITY_EN is defined.
// Optional: TDM_DEMUX_PARITY_EN adds a 9th even-parity slot and parity_err.
module tdm_demux8 #(
   parameter int DATA_W          = 1,
   parameter int SYNC_LOSS_LIMIT = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  en,
   input  logic [DATA_W-1:0]     din,
   input  logic                  fsync,
   output logic [8*DATA_W-1:0]   q,
   output logic                  frame_valid,
`ifdef TDM_DEMUX_PARITY_EN
   output logic [3:0]            sel,
   output logic                  parity_err,
`else
   output logic [2:0]            sel,
`endif
   output logic                  locked,
   output logic                  sync_err
);

`ifdef TDM_DEMUX_PARITY_EN
   localparam int SEL_W = 4;
   localparam logic [SEL_W-1:0] LAST = 4'd8;
`else
   localparam int SEL_W = 3;
   localparam logic [SEL_W-1:0] LAST = 3'd7;
`endif
   localparam logic [2:0] LIMIT = 3'(SYNC_LOSS_LIMIT);

   typedef enum logic {HUNT, LOCKED} state_t;

   state_t                state_q, state_d;
   logic [SEL_W-1:0]      sel_q, sel_d;
   logic [8*DATA_W-1:0]   shadow_q, shadow_d;
   logic [8*DATA_W-1:0]   q_q, q_d;
   logic [2:0]            miss_q, miss_d;
   logic [2:0]            miss_inc;
   logic                  fv_q, fv_d;
   logic                  serr_q, serr_d;
   logic                  bad;
`ifdef TDM_DEMUX_PARITY_EN
   logic                  perr_q, perr_d;
`endif

   always_comb begin
      state_d  = state_q;
      sel_d    = sel_q;
      shadow_d = shadow_q;
      q_d      = q_q;
      miss_d   = miss_q;
      fv_d     = 1'b0;
      serr_d   = 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
      perr_d   = 1'b0;
`endif
      miss_inc = miss_q + 3'd1;
      // A sync check fails when fsync is missing at slot 0 or appears elsewhere.
      bad      = (sel_q == '0) ? !fsync : fsync;
      if (en) begin
         unique case (state_q)
            HUNT: begin
               if (fsync) begin
                  shadow_d[0 +: DATA_W] = din;
                  sel_d   = SEL_W'(1);
                  miss_d  = 3'd0;
                  state_d = LOCKED;
               end
            end
            LOCKED: begin
               if (bad) begin
                  serr_d = 1'b1;
                  miss_d = miss_inc;
                  if (miss_inc >= LIMIT) begin
                     state_d = HUNT;
                     sel_d   = '0;
                  end else begin
                     // Drop the partial frame; this sample starts a new one.
                     shadow_d              = '0;
                     shadow_d[0 +: DATA_W] = din;
                     sel_d                 = SEL_W'(1);
                  end
               end else begin
                  if (sel_q == '0) miss_d = 3'd0;
                  for (int k = 0; k < 8; k++) begin
                     if (sel_q == SEL_W'(k)) shadow_d[k*DATA_W +: DATA_W] = din;
                  end
                  if (sel_q == LAST) begin
                     sel_d = '0;
                     fv_d  = 1'b1;
`ifdef TDM_DEMUX_PARITY_EN
                     q_d    = shadow_q;
                     perr_d = (^shadow_q) != din[0];
`else
                     q_d    = shadow_d;
`endif
                  end else begin
                     sel_d = sel_q + SEL_W'(1);
                  end
               end
            end
            default: state_d = HUNT;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= HUNT;
         sel_q    <= '0;
         shadow_q <= '0;
         q_q      <= '0;
         miss_q   <= 3'd0;
         fv_q     <= 1'b0;
         serr_q   <= 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
         perr_q   <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         sel_q    <= sel_d;
         shadow_q <= shadow_d;
         q_q      <= q_d;
         miss_q   <= miss_d;
         fv_q     <= fv_d;
         serr_q   <= serr_d;
`ifdef TDM_DEMUX_PARITY_EN
         perr_q   <= perr_d;
`endif
      end
   end

   assign q           = q_q;
   assign frame_valid = fv_q;
   assign sel         = sel_q;
   assign locked      = (state_q == LOCKED);
   assign sync_err    = serr_q;
`ifdef TDM_DEMUX_PARITY_EN
   assign parity_err  = perr_q;
`endif

endmodule

// File: tb/tb_tdm_demux8.sv
// tb_tdm_demux8: table-driven bench for tdm_demux8 with a frame scoreboard.
// Expected frames are queued when their last slot is driven.
module tb_tdm_demux8;
`ifdef TDM_DEMUX_PARITY_EN
   localparam int NS = 9;
   localparam int SW = 4;
`else
   localparam int NS = 8;
   localparam int SW = 3;
`endif

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          en = 1'b0;
   logic [0:0]    din = 1'b0;
   logic          fsync = 1'b0;
   logic [7:0]    q;
   logic          fv;
   logic [SW-1:0] sel;
   logic          locked;
   logic          serr;
`ifdef TDM_DEMUX_PARITY_EN
   logic          perr;
`endif

   always #5 clk = ~clk;

   tdm_demux8 #(.DATA_W(1), .SYNC_LOSS_LIMIT(2)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .en(en),
      .din(din),
      .fsync(fsync),
      .q(q),
      .frame_valid(fv),
      .sel(sel),
`ifdef TDM_DEMUX_PARITY_EN
      .parity_err(perr),
`endif
      .locked(locked),
      .sync_err(serr)
   );

   typedef struct {
      logic          en;
      logic          din;
      logic          fs;
      logic [SW-1:0] sel;
      logic          lk;
      logic          se;
      logic          fv;
      logic          pe;
      logic          qc;
      logic [7:0]    qv;
   } vec_t;

   vec_t       vecs[$];
   logic [7:0] sb[$];
   int         tests = 0;
   int         fails = 0;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic add(input logic e, input logic d, input logic f,
                      input int s, input logic lk, input logic se,
                      input logic fvv, input logic pe, input logic qc,
                      input logic [7:0] qv);
      vec_t v;
      v.en = e; v.din = d; v.fs = f; v.sel = SW'(s);
      v.lk = lk; v.se = se; v.fv = fvv; v.pe = pe;
      v.qc = qc; v.qv = qv;
      vecs.push_back(v);
   endtask

   // One frame starting at slot 0; ch k = f[k]; optional en gaps.
   task automatic send_frame(input logic [7:0] f, input logic fs0,
                             input logic se0, input logic gap,
                             input logic pflip);
      logic d;
      for (int i = 0; i < NS; i++) begin
         d = (i < 8) ? f[i[2:0]] : ((^f) ^ pflip);
         add(1'b1, d, fs0 && i == 0, (i + 1) % NS, 1'b1, se0 && i == 0,
             i == NS - 1, pflip && i == NS - 1, 1'b0, f);
         if (gap) add(1'b0, 1'b0, 1'b0, (i + 1) % NS, 1'b1, 1'b0,
                      1'b0, 1'b0, 1'b0, f);
      end
   endtask

   // n good samples from slot 0 of a fresh frame.
   task automatic pre(input int n);
      for (int i = 0; i < n; i++)
         add(1'b1, i[0], i == 0, i + 1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
   endtask

   task automatic run_vecs();
      vec_t v;
      while (vecs.size() > 0) begin
         v = vecs.pop_front();
         @(negedge clk);
         en = v.en; din = v.din; fsync = v.fs;
         if (v.fv) sb.push_back(v.qv);
         @(posedge clk);
         #1;
         chk("sel", 32'(sel), 32'(v.sel));
         chk("locked", 32'(locked), 32'(v.lk));
         chk("sync_err", 32'(serr), 32'(v.se));
         chk("frame_valid", 32'(fv), 32'(v.fv));
`ifdef TDM_DEMUX_PARITY_EN
         chk("parity_err", 32'(perr), 32'(v.pe));
`endif
         if (fv) begin
            if (sb.size() > 0) chk("q_frame", 32'(q), 32'(sb.pop_front()));
            else chk("sb_underflow", 32'(sb.size()), 32'd1);
         end
         if (v.qc) chk("q_hold", 32'(q), 32'(v.qv));
      end
      @(negedge clk);
      en = 1'b0; fsync = 1'b0; din = 1'b0;
   endtask

   initial begin
      #1;
      chk("rst_q", 32'(q), 32'd0);
      chk("rst_sel", 32'(sel), 32'd0);
      chk("rst_locked", 32'(locked), 32'd0);
      chk("rst_fv", 32'(fv), 32'd0);
      chk("rst_serr", 32'(serr), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Hunting: en=0 and samples without fsync do nothing.
      add(1'b0, 1'b1, 1'b1, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
      add(1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
      // Basic frame 1,0,1,1,0,0,1,0.
      send_frame(8'h4D, 1'b1, 1'b0, 1'b0, 1'b0);
      // Gapped back-to-back frames.
      send_frame(8'hA5, 1'b1, 1'b0, 1'b1, 1'b0);
      send_frame(8'h3C, 1'b1, 1'b0, 1'b1, 1'b0);
      send_frame(8'hF0, 1'b1, 1'b0, 1'b1, 1'b0);
      // fsync on the 4th sample re-aligns.
      pre(3);
      send_frame(8'h96, 1'b1, 1'b1, 1'b0, 1'b0);
      send_frame(8'h5A, 1'b1, 1'b0, 1'b0, 1'b0);
      // fsync on the last slot: no publish, re-align.
      pre(NS - 1);
      send_frame(8'h69, 1'b1, 1'b1, 1'b0, 1'b0);
      send_frame(8'h0F, 1'b1, 1'b0, 1'b0, 1'b0);
      // Two missing syncs lose lock; q holds; fsync relocks.
      send_frame(8'h71, 1'b0, 1'b1, 1'b0, 1'b0);
      add(1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h71);
      add(1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h71);
      send_frame(8'hC3, 1'b1, 1'b0, 1'b0, 1'b0);
      // Partial frame up to sel=5, then async reset.
      pre(5);
      run_vecs();

      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_q", 32'(q), 32'd0);
      chk("arst_sel", 32'(sel), 32'd0);
      chk("arst_locked", 32'(locked), 32'd0);
      chk("arst_fv", 32'(fv), 32'd0);
      chk("arst_serr", 32'(serr), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      add(1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
      add(1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
      send_frame(8'h2B, 1'b1, 1'b0, 1'b0, 1'b0);
`ifdef TDM_DEMUX_PARITY_EN
      send_frame(8'hA5, 1'b1, 1'b0, 1'b0, 1'b0);
      send_frame(8'hA5, 1'b1, 1'b0, 1'b0, 1'b1);
`endif
      run_vecs();

      chk("sb_left", 32'(sb.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
